// File: rtl/conv3x3_stream.sv
// Streaming 3x3 filter (blur / sharpen / over-sharpen) over a raster pixel stream with two line buffers.
// Latency: 2 cycles from the accepted interior pixel to out_valid; 1 pixel/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; every stage holds while the output is stalled.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready      input handshake for in_pix (raster order, col fastest)
//   in_pix [PIX_W]         unsigned input pixel
//   ksel [2]               filter select, sampled on the first pixel of a frame only
//   out_valid/out_ready    output handshake for out_pix
//   out_pix [PIX_W]        filtered pixel clamped to [0, 2^PIX_W-1]
//   frame_done             high in the cycle the last output of a frame is transferred
module conv3x3_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic [1:0]       ksel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = PIX_W + 6;
    localparam logic signed [AW-1:0] PIX_MAX = AW'((1 << PIX_W) - 1);

    localparam logic [1:0] MODE_BLUR    = 2'b00;
    localparam logic [1:0] MODE_SHARPEN = 2'b01;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic adv;
    logic in_xfer;

    logic out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic out_last_q, out_last_d;

    // The whole pipeline moves together; it only stops when the output
    // register holds a pixel the consumer has not taken.
    assign adv      = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && adv;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Raster position and frame mode
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    mode_q, mode_d;

    logic first_pix;
    logic interior_pix;
    logic last_pix;

    assign first_pix    = (col_q == '0) && (row_q == '0);
    assign interior_pix = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_pix     = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        if (in_xfer) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // Filter choice is frozen for the frame at its first pixel.
            if (first_pix) begin
                mode_d = ksel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by col.
    // Contents need no reset: rows 0 and 1 of a frame never produce output,
    // so stale data from a previous frame is never used.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] lb1_mem [IMG_W];
    logic [PIX_W-1:0] lb2_mem [IMG_W];
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;

    assign lb1_rd = lb1_mem[col_q];
    assign lb2_rd = lb2_mem[col_q];

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            lb1_mem[col_q] <= in_pix;
            lb2_mem[col_q] <= lb1_rd;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window shift register, plus the qualifiers travelling
    // with it. win[i][j]: i=0 top row, j=0 oldest column, centre win[1][1].
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic             s1_vld_q, s1_vld_d;
    logic             s1_last_q, s1_last_d;
    logic [1:0]       s1_mode_q, s1_mode_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_d[i][j] = win_q[i][j];
            end
        end
        if (in_xfer) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = in_pix;
        end
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_mode_d = s1_mode_q;
        if (adv) begin
            // Border windows straddle rows or mix in the previous row's tail;
            // they are shifted through but never marked valid.
            s1_vld_d  = in_xfer && interior_pix;
            s1_last_d = in_xfer && last_pix;
            if (in_xfer) begin
                // Carry the mode with the window so a new frame's first pixel
                // cannot retarget the previous frame's final window.
                s1_mode_d = mode_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: kernel arithmetic, clamp, output register
    // ------------------------------------------------------------------
    function automatic logic signed [AW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({6'b0, p});
    endfunction

    logic signed [AW-1:0] sum9;
    logic signed [AW-1:0] ctr;
    logic signed [AW-1:0] nb4;
    logic signed [AW-1:0] nb8;
    logic signed [AW-1:0] res;
    logic [PIX_W-1:0]     res_clamped;

    always_comb begin
        sum9 = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum9 = sum9 + ext(win_q[i][j]);
            end
        end
        ctr = ext(win_q[1][1]);
        nb4 = ext(win_q[0][1]) + ext(win_q[1][0]) + ext(win_q[1][2]) + ext(win_q[2][1]);
        nb8 = sum9 - ctr;

        case (s1_mode_q)
            MODE_BLUR:    res = sum9 >>> 3;
            MODE_SHARPEN: res = (ctr <<< 2) + ctr - nb4;
            default:      res = (ctr <<< 3) + ctr - nb8;
        endcase

        if (res[AW-1]) begin
            res_clamped = '0;
        end else if (res > PIX_MAX) begin
            res_clamped = PIX_MAX[PIX_W-1:0];
        end else begin
            res_clamped = res[PIX_W-1:0];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_last_d  = out_last_q;
        if (adv) begin
            out_valid_d = s1_vld_q;
            out_last_d  = s1_last_q;
            if (s1_vld_q) begin
                out_pix_d = res_clamped;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_BLUR;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= MODE_BLUR;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= win_d[i][j];
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pix    = out_pix_q;
    // Combinational on out_ready so the pulse lands in the transfer cycle itself.
    assign frame_done = out_valid_q && out_ready && out_last_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: a 4x4 and a 5x5 instance share stimulus,
// use5 selects which one receives pixels and which one is observed.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_conv3x3_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_pix;
    logic [1:0] ksel;
    logic       use5;

    logic       a_in_ready, a_out_valid, a_frame_done;
    logic [7:0] a_out_pix;
    logic       b_in_ready, b_out_valid, b_frame_done;
    logic [7:0] b_out_pix;

    logic       o_in_ready, o_out_valid, o_frame_done;
    logic [7:0] o_out_pix;

    assign o_in_ready   = use5 ? b_in_ready   : a_in_ready;
    assign o_out_valid  = use5 ? b_out_valid  : a_out_valid;
    assign o_frame_done = use5 ? b_frame_done : a_frame_done;
    assign o_out_pix    = use5 ? b_out_pix    : a_out_pix;

    always #5 clk = ~clk;

    conv3x3_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid && !use5),
        .in_ready   (a_in_ready),
        .in_pix     (in_pix),
        .ksel       (ksel),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .out_pix    (a_out_pix),
        .frame_done (a_frame_done)
    );

    conv3x3_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid && use5),
        .in_ready   (b_in_ready),
        .in_pix     (in_pix),
        .ksel       (ksel),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .out_pix    (b_out_pix),
        .frame_done (b_frame_done)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         tick_cnt = 0;
    int         first_out = 0;
    int         fd_cnt = 0;
    int         base = 0;
    int         sent_ticks = 0;
    bit         acc = 1'b0;
    bit         rand_rdy = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix = 8'd0;
    logic [7:0] got_q [$];
    int         exp_v [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        tick_cnt++;
        acc = in_valid && o_in_ready;
        if (prev_stall) begin
            chk("hold_valid", {31'd0, o_out_valid}, 32'd1);
            chk("hold_pix", {24'd0, o_out_pix}, {24'd0, prev_pix});
        end
        if (o_out_valid && !out_ready) chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
        if (o_out_valid && out_ready) got_q.push_back(o_out_pix);
        if (o_out_valid && first_out == 0) first_out = tick_cnt;
        if (o_frame_done) fd_cnt++;
        prev_stall = o_out_valid && !out_ready;
        prev_pix   = o_out_pix;
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // kind 0: constant v; kind 1: v at (2,2) else 0; kind 2: ramp 16*r+3*c.
    task automatic send_frame(input int w, input int h, input int kind, input int v,
                              input logic [1:0] k0, input logic [1:0] k1,
                              input int sw, input int npix);
        int n;
        int idx;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                idx = r * w + c;
                if (idx < npix) begin
                    ksel = (idx < sw) ? k0 : k1;
                    case (kind)
                        0:       in_pix = 8'(v);
                        1:       in_pix = (r == 2 && c == 2) ? 8'(v) : 8'd0;
                        default: in_pix = 8'(16 * r + 3 * c);
                    endcase
                    in_valid = 1'b1;
                    acc = 1'b0;
                    n = 0;
                    while (!acc && n < 100) begin
                        tick();
                        n++;
                    end
                    chk("in_accept", {31'd0, acc}, 32'd1);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int kind, input int v,
                             input logic [1:0] k0, input logic [1:0] k1, input int sw, input int nexp);
        got_q.delete();
        fd_cnt = 0;
        first_out = 0;
        base = tick_cnt;
        send_frame(w, h, kind, v, k0, k1, sw, w * h);
        sent_ticks = tick_cnt - base;
        repeat (40) tick();
        chk($sformatf("%s_count", tag), got_q.size(), nexp);
        for (int i = 0; i < nexp; i++) begin
            if (i < got_q.size()) chk($sformatf("%s_pix%0d", tag, i), {24'd0, got_q[i]}, exp_v[i]);
        end
        chk($sformatf("%s_frame_done", tag), fd_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pix = 8'd0;
        ksel = 2'b00;
        out_ready = 1'b1;
        use5 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_pix", {24'd0, a_out_pix}, 32'd0);
        chk("rst_frame_done", {31'd0, a_frame_done}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_out_valid5", {31'd0, b_out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: flat 100, blur -> 900>>3 = 112; back-to-back, 2-cycle latency
        exp_v = '{112, 112, 112, 112, 0, 0, 0, 0, 0};
        run_frame("t1_blur", 4, 4, 0, 100, 2'b00, 2'b00, 1000, 4);
        chk("t1_throughput", sent_ticks, 16);
        chk("t1_latency", first_out - base, 13);

        // T2: flat frames are invariant under sharpen and over-sharpen
        exp_v = '{100, 100, 100, 100, 0, 0, 0, 0, 0};
        run_frame("t2_sharp", 4, 4, 0, 100, 2'b01, 2'b01, 1000, 4);
        run_frame("t2_over", 4, 4, 0, 100, 2'b10, 2'b10, 1000, 4);

        // Blur high clamp: 2295>>3 = 286 -> 255
        exp_v = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
        run_frame("blur_clamp", 4, 4, 0, 255, 2'b00, 2'b00, 1000, 4);

        // T3: 5x5 impulse 255 at (2,2)
        use5 = 1'b1;
        exp_v = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
        run_frame("t3_sharp", 5, 5, 1, 255, 2'b01, 2'b01, 1000, 9);
        exp_v = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
        run_frame("t3_over", 5, 5, 1, 255, 2'b11, 2'b11, 1000, 9);
        exp_v = '{31, 31, 31, 31, 31, 31, 31, 31, 31};
        run_frame("t3_blur", 5, 5, 1, 255, 2'b00, 2'b00, 1000, 9);
        use5 = 1'b0;

        // T4: ramp blur, first with ready held high, then with random stalls
        exp_v = '{21, 24, 39, 42, 0, 0, 0, 0, 0};
        run_frame("t4_ready", 4, 4, 2, 0, 2'b00, 2'b00, 1000, 4);
        rand_rdy = 1'b1;
        run_frame("t4_stall", 4, 4, 2, 0, 2'b00, 2'b00, 1000, 4);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();

        // T5: ksel change mid-frame ignored, takes effect next frame
        exp_v = '{21, 24, 39, 42, 0, 0, 0, 0, 0};
        run_frame("t5_blur", 4, 4, 2, 0, 2'b00, 2'b01, 5, 4);
        exp_v = '{19, 22, 35, 38, 0, 0, 0, 0, 0};
        run_frame("t5_sharp", 4, 4, 2, 0, 2'b01, 2'b01, 1000, 4);

        // T6: reset after 7 pixels, then a clean frame
        send_frame(4, 4, 2, 0, 2'b01, 2'b01, 1000, 7);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("t6_frame_done", {31'd0, a_frame_done}, 32'd0);
        prev_stall = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_v = '{21, 24, 39, 42, 0, 0, 0, 0, 0};
        run_frame("t6_after", 4, 4, 2, 0, 2'b00, 2'b00, 1000, 4);

        // Reset while an output is pending and stalled
        out_ready = 1'b0;
        send_frame(4, 4, 2, 0, 2'b00, 2'b00, 1000, 11);
        repeat (2) tick();
        chk("t6b_pending", {31'd0, a_out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6b_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("t6b_in_ready", {31'd0, a_in_ready}, 32'd1);
        prev_stall = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        exp_v = '{19, 22, 35, 38, 0, 0, 0, 0, 0};
        run_frame("t6b_after", 4, 4, 2, 0, 2'b01, 2'b01, 1000, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
